// File: rtl/sccb_cmd_arbiter_if.sv
// Command bus between the two register-write sources, the arbiter and the SCCB master.
// Handshakes: reqX_valid is held with stable addr/data until the one-cycle reqX_ack; m_send is a level held
// with stable m_reg*/m_value until the one-cycle m_taken pulse (or the arbiter's timeout).
interface sccb_cmd_arbiter_if;
    logic        req0_valid;
    logic        req0_lock;
    logic [15:0] req0_addr;
    logic [7:0]  req0_data;
    logic        req0_ack;
    logic        req1_valid;
    logic [15:0] req1_addr;
    logic [7:0]  req1_data;
    logic        req1_ack;
    logic        ack_err;
    logic        m_send;
    logic [7:0]  m_regah;
    logic [7:0]  m_regal;
    logic [7:0]  m_value;
    logic        m_taken;
    logic        busy;
    logic        grant_id;
    logic [1:0]  state_dbg;

    modport master (
        input  req0_valid, req0_lock, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        input  m_taken,
        output req0_ack, req1_ack, ack_err,
        output m_send, m_regah, m_regal, m_value,
        output busy, grant_id, state_dbg
    );

    modport slave (
        output req0_valid, req0_lock, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        output m_taken,
        input  req0_ack, req1_ack, ack_err,
        input  m_send, m_regah, m_regal, m_value,
        input  busy, grant_id, state_dbg
    );
endinterface

// File: rtl/sccb_cmd_arbiter.sv
// Two-source arbiter in front of the SCCB register-write master: round-robin with a requester-0 burst lock,
// a post-command bus gap and an ISSUE watchdog.
module sccb_cmd_arbiter #(
    parameter int unsigned GAP_CYCLES     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 2_500_000,
    parameter int unsigned CNT_W          = 32
) (
    input  logic               clk,
    input  logic               rst,
    sccb_cmd_arbiter_if.master bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           r_state, w_state_nxt;
    logic             r_send, w_send_nxt;
    logic [7:0]       r_regah, w_regah_nxt;
    logic [7:0]       r_regal, w_regal_nxt;
    logic [7:0]       r_value, w_value_nxt;
    logic             r_ack0, w_ack0_nxt;
    logic             r_ack1, w_ack1_nxt;
    logic             r_err, w_err_nxt;
    logic             r_grant, w_grant_nxt;
    logic             r_last, w_last_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

    logic             w_any_valid;
    logic             w_pick1;
    logic [CNT_W-1:0] w_cnt_inc;

    assign w_any_valid = bus.req0_valid | bus.req1_valid;
    // Tie goes to whoever was not granted last, except a locked requester 0 keeps the bus after its own grant.
    assign w_pick1     = bus.req1_valid & (~bus.req0_valid | (~r_last & ~bus.req0_lock));
    assign w_cnt_inc   = (r_cnt == '1) ? r_cnt : r_cnt + CNT_ONE;

    always_comb begin
        w_state_nxt = r_state;
        w_send_nxt  = r_send;
        w_regah_nxt = r_regah;
        w_regal_nxt = r_regal;
        w_value_nxt = r_value;
        w_ack0_nxt  = 1'b0;
        w_ack1_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        w_grant_nxt = r_grant;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_any_valid) begin
                    w_state_nxt = ST_ISSUE;
                    w_send_nxt  = 1'b1;
                    w_cnt_nxt   = '0;
                    w_grant_nxt = w_pick1;
                    w_last_nxt  = w_pick1;
                    {w_regah_nxt, w_regal_nxt} = w_pick1 ? bus.req1_addr : bus.req0_addr;
                    w_value_nxt = w_pick1 ? bus.req1_data : bus.req0_data;
                end
            end
            ST_ISSUE: begin
                // A take in the expiry cycle still counts as success.
                if (bus.m_taken || (r_cnt >= TO_LAST)) begin
                    w_state_nxt = ST_DONE;
                    w_send_nxt  = 1'b0;
                    w_ack0_nxt  = ~r_grant;
                    w_ack1_nxt  = r_grant;
                    w_err_nxt   = ~bus.m_taken;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            ST_DONE: begin
                w_cnt_nxt   = '0;
                w_state_nxt = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
            end
            ST_GAP: begin
                if (r_cnt >= GAP_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_send  <= 1'b0;
            r_regah <= '0;
            r_regal <= '0;
            r_value <= '0;
            r_ack0  <= 1'b0;
            r_ack1  <= 1'b0;
            r_err   <= 1'b0;
            r_grant <= 1'b0;
            r_last  <= 1'b1;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_send  <= w_send_nxt;
            r_regah <= w_regah_nxt;
            r_regal <= w_regal_nxt;
            r_value <= w_value_nxt;
            r_ack0  <= w_ack0_nxt;
            r_ack1  <= w_ack1_nxt;
            r_err   <= w_err_nxt;
            r_grant <= w_grant_nxt;
            r_last  <= w_last_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign bus.req0_ack  = r_ack0;
    assign bus.req1_ack  = r_ack1;
    assign bus.ack_err   = r_err;
    assign bus.m_send    = r_send;
    assign bus.m_regah   = r_regah;
    assign bus.m_regal   = r_regal;
    assign bus.m_value   = r_value;
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.grant_id  = r_grant;
    assign bus.state_dbg = r_state;
endmodule

// File: tb/tb_sccb_cmd_arbiter.sv
// Bench for sccb_cmd_arbiter: table of arbitration rounds checked through an expected-ack queue,
// plus hand sequences for gap timing, withdrawal, spurious take and reset mid-ISSUE.
module tb_sccb_cmd_arbiter;
    localparam int GAP   = 16;
    localparam int TMO   = 100;
    localparam int NEVER = 255;
    localparam int EW    = 34;

    typedef struct {
        int          n0;
        int          n1;
        logic        lock;
        logic [15:0] a0;
        logic [15:0] a1;
        logic [7:0]  d0;
        logic [7:0]  d1;
        int          dly;
        logic [3:0]  order;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic resp_taken = 1'b0;
    logic spur_taken = 1'b0;
    int   taken_dly = NEVER;
    int   errors = 0;
    int   checks = 0;
    logic [EW-1:0] exp_q[$];
    vec_t vecs[11];

    sccb_cmd_arbiter_if bus();
    assign bus.m_taken = resp_taken | spur_taken;

    sccb_cmd_arbiter #(
        .GAP_CYCLES(GAP),
        .TIMEOUT_CYCLES(TMO),
        .CNT_W(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #10 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Expected ack record: {id, err, addr, data, cycles m_send was high}
    function automatic logic [EW-1:0] mk_exp(input logic id, input int dly, input logic [15:0] a, input logic [7:0] d);
        logic       err;
        logic [7:0] len;
        err = (dly >= TMO);
        len = err ? 8'(TMO) : 8'(dly + 1);
        return {id, err, a, d, len};
    endfunction

    initial begin : monitor
        logic          prev_send;
        logic [24:0]   cap;
        int            send_len;
        logic [EW-1:0] e;
        logic [EW-1:0] o;
        prev_send = 1'b0;
        cap = '0;
        send_len = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_send = 1'b0;
                send_len = 0;
            end else begin
                if (bus.m_send) begin
                    if (!prev_send) begin
                        cap = {bus.grant_id, bus.m_regah, bus.m_regal, bus.m_value};
                        send_len = 0;
                    end else begin
                        chk("m_stable", {bus.grant_id, bus.m_regah, bus.m_regal, bus.m_value}, cap);
                    end
                    send_len++;
                end
                if (bus.req0_ack || bus.req1_ack) begin
                    chk("ack_onehot", bus.req0_ack & bus.req1_ack, 0);
                    chk("ack_no_send", bus.m_send, 0);
                    chk("ack_id", bus.req1_ack, cap[24]);
                    chk("ack_pending", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        o = {cap[24], bus.ack_err, cap[23:0], 8'(send_len)};
                        chk("sb_ack", o, e);
                    end
                end
                prev_send = bus.m_send;
            end
        end
    end

    initial begin : responder
        int g;
        forever begin
            @(negedge clk);
            if (!rst && bus.m_send) begin
                if (taken_dly < NEVER) begin
                    repeat (taken_dly) @(negedge clk);
                    if (bus.m_send && !rst) begin
                        resp_taken = 1'b1;
                        @(negedge clk);
                        resp_taken = 1'b0;
                    end
                end
                g = 0;
                while (bus.m_send && g < 2000) begin
                    @(negedge clk);
                    g++;
                end
            end
        end
    end

    task automatic wait_idle();
        int g;
        g = 0;
        while (bus.busy && g < 300) begin
            @(negedge clk);
            g++;
        end
        chk("idle_reached", bus.busy, 0);
    endtask

    task automatic run_round(input int n0, input int n1, input logic lock, input logic [15:0] a0,
                             input logic [15:0] a1, input logic [7:0] d0, input logic [7:0] d1,
                             input int dly, input logic [3:0] order);
        int k0, k1, rem0, rem1, g;
        k0 = 0;
        k1 = 0;
        for (int i = 0; i < n0 + n1; i++) begin
            if (order[i] == 1'b0) begin
                exp_q.push_back(mk_exp(1'b0, dly, a0 + 16'(k0), d0 + 8'(k0)));
                k0++;
            end else begin
                exp_q.push_back(mk_exp(1'b1, dly, a1 + 16'(k1), d1 + 8'(k1)));
                k1++;
            end
        end
        taken_dly = dly;
        @(negedge clk);
        rem0 = n0;
        rem1 = n1;
        k0 = 0;
        k1 = 0;
        bus.req0_lock  = lock;
        bus.req0_valid = (n0 > 0);
        bus.req0_addr  = a0;
        bus.req0_data  = d0;
        bus.req1_valid = (n1 > 0);
        bus.req1_addr  = a1;
        bus.req1_data  = d1;
        g = 0;
        while ((rem0 > 0 || rem1 > 0) && g < 4000) begin
            @(negedge clk);
            g++;
            if (bus.req0_ack && rem0 > 0) begin
                rem0--;
                k0++;
                if (rem0 > 0) begin
                    bus.req0_addr = a0 + 16'(k0);
                    bus.req0_data = d0 + 8'(k0);
                end else begin
                    bus.req0_valid = 1'b0;
                end
            end
            if (bus.req1_ack && rem1 > 0) begin
                rem1--;
                k1++;
                if (rem1 > 0) begin
                    bus.req1_addr = a1 + 16'(k1);
                    bus.req1_data = d1 + 8'(k1);
                end else begin
                    bus.req1_valid = 1'b0;
                end
            end
        end
        chk("round_done", (rem0 == 0) && (rem1 == 0), 1);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.req0_lock  = 1'b0;
        wait_idle();
        chk("sb_drain", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: actual=no_finish required=finish");
        $fatal(1, "simulation time limit");
    end

    initial begin : main
        int   g;
        logic got;
        logic prev_tk;

        bus.req0_valid = 1'b0;
        bus.req0_lock  = 1'b0;
        bus.req0_addr  = '0;
        bus.req0_data  = '0;
        bus.req1_valid = 1'b0;
        bus.req1_addr  = '0;
        bus.req1_data  = '0;

        // n0, n1, lock, a0, a1, d0, d1, taken delay, ack order (bit i = id of i-th ack)
        vecs[0]  = '{1, 1, 1'b0, 16'h3500, 16'h3501, 8'h00, 8'h20, 3,     4'b0010};
        vecs[1]  = '{3, 1, 1'b1, 16'h3000, 16'h3100, 8'h10, 8'h40, 2,     4'b1000};
        vecs[2]  = '{2, 2, 1'b0, 16'h3010, 16'h3110, 8'ha0, 8'hb0, 4,     4'b1010};
        vecs[3]  = '{0, 1, 1'b0, 16'h0000, 16'h5001, 8'h00, 8'h33, 0,     4'b0001};
        vecs[4]  = '{1, 0, 1'b0, 16'h3503, 16'h0000, 8'h7f, 8'h00, NEVER, 4'b0000};
        vecs[5]  = '{1, 1, 1'b0, 16'h1234, 16'habcd, 8'h56, 8'hef, 1,     4'b0001};
        vecs[6]  = '{0, 1, 1'b1, 16'h0000, 16'h4000, 8'h00, 8'h01, 2,     4'b0001};
        vecs[7]  = '{1, 0, 1'b0, 16'h0a0b, 16'h0000, 8'h0c, 8'h00, TMO-1, 4'b0000};
        vecs[8]  = '{0, 1, 1'b0, 16'h0000, 16'h0d0e, 8'h00, 8'h0f, TMO,   4'b0001};
        vecs[9]  = '{1, 0, 1'b0, 16'h2000, 16'h0000, 8'h11, 8'h00, 2,     4'b0000};
        vecs[10] = '{2, 1, 1'b1, 16'h2100, 16'h2200, 8'h21, 8'h31, 3,     4'b0100};

        repeat (3) @(negedge clk);
        #1;
        chk("rst_m_send", bus.m_send, 0);
        chk("rst_m_bytes", {bus.m_regah, bus.m_regal, bus.m_value}, 0);
        chk("rst_acks", {bus.req0_ack, bus.req1_ack, bus.ack_err}, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_grant", bus.grant_id, 0);
        chk("rst_state", bus.state_dbg, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < 11; v++)
            run_round(vecs[v].n0, vecs[v].n1, vecs[v].lock, vecs[v].a0, vecs[v].a1,
                      vecs[v].d0, vecs[v].d1, vecs[v].dly, vecs[v].order);

        // Single write: ack one cycle after take, then exactly GAP busy cycles; req1 pulse inside the gap.
        taken_dly = 5;
        exp_q.push_back(mk_exp(1'b0, 5, 16'h0100, 8'h01));
        @(negedge clk);
        bus.req0_valid = 1'b1;
        bus.req0_addr  = 16'h0100;
        bus.req0_data  = 8'h01;
        g = 0;
        got = 1'b0;
        prev_tk = 1'b0;
        while (!got && g < 500) begin
            @(negedge clk);
            #1;
            g++;
            if (bus.req0_ack) got = 1'b1;
            else prev_tk = bus.m_taken;
        end
        chk("single_ack_seen", got, 1);
        chk("single_ack_after_taken", prev_tk, 1);
        chk("single_ack_err", bus.ack_err, 0);
        bus.req0_valid = 1'b0;
        for (int i = 1; i <= GAP; i++) begin
            @(negedge clk);
            #1;
            chk("gap_busy", bus.busy, 1);
            if (i == 1) chk("ack_one_cycle", bus.req0_ack, 0);
            if (i == 5) begin
                bus.req1_valid = 1'b1;
                bus.req1_addr  = 16'h7777;
                bus.req1_data  = 8'h77;
            end
            if (i == 6) bus.req1_valid = 1'b0;
        end
        @(negedge clk);
        #1;
        chk("gap_end_idle", bus.busy, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            chk("withdrawn_no_grant", {bus.m_send, bus.busy}, 0);
        end
        chk("single_sb_drain", exp_q.size(), 0);

        // Spurious take while idle.
        @(negedge clk);
        spur_taken = 1'b1;
        @(negedge clk);
        spur_taken = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("spurious_taken", {bus.busy, bus.req0_ack, bus.req1_ack, bus.state_dbg}, 0);
        end

        // Reset three cycles into ISSUE: m_send drops at once, no ack, round-robin state restored.
        taken_dly = NEVER;
        @(negedge clk);
        bus.req0_valid = 1'b1;
        bus.req0_addr  = 16'h1111;
        bus.req0_data  = 8'h22;
        bus.req1_valid = 1'b1;
        bus.req1_addr  = 16'h3333;
        bus.req1_data  = 8'h44;
        g = 0;
        while (!bus.m_send && g < 50) begin
            @(negedge clk);
            #1;
            g++;
        end
        chk("rst_issue_send", bus.m_send, 1);
        repeat (3) @(posedge clk);
        #5;
        rst = 1'b1;
        #1;
        chk("rst_mid_send", bus.m_send, 0);
        chk("rst_mid_busy", bus.busy, 0);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("rst_mid_no_ack", {bus.req0_ack, bus.req1_ack}, 0);
        end
        @(negedge clk);
        rst = 1'b0;
        run_round(1, 1, 1'b0, 16'h3500, 16'h3501, 8'h00, 8'h20, 2, 4'b0010);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
